// File: rtl/msm_pkg.sv
// Shared MSM datapath definitions: word layout, BUBBLE constant, PADD operand select
// encodings and result-buffer occupancy classes.
package msm_pkg;

  localparam int unsigned MSM_WIDTH_ID   = 2;
  localparam int unsigned MSM_WIDTH_DATA = 384;
  localparam int unsigned MSM_WORD_W     = MSM_WIDTH_ID + 3 * MSM_WIDTH_DATA;

  localparam logic [MSM_WORD_W-1:0] BUBBLE = '0;

  // Word layout {id, X, Y, Z}, Z in the least significant bits.
  localparam int unsigned Z_LSB  = 0;
  localparam int unsigned Y_LSB  = MSM_WIDTH_DATA;
  localparam int unsigned X_LSB  = 2 * MSM_WIDTH_DATA;
  localparam int unsigned ID_LSB = 3 * MSM_WIDTH_DATA;

  typedef enum logic [1:0] {
    SelARb      = 2'd0,
    SelABucketA = 2'd1,
    SelABucketB = 2'd2,
    SelABubble  = 2'd3
  } padd_sel_a_e;

  typedef enum logic [1:0] {
    SelBRb      = 2'd0,
    SelBPm      = 2'd1,
    SelBBubble  = 2'd2,
    SelBBubble3 = 2'd3
  } padd_sel_b_e;

  typedef enum logic [1:0] {
    OccEmpty = 2'd0,
    OccOne   = 2'd1,
    OccMulti = 2'd2,
    OccFull  = 2'd3
  } rb_occ_e;

endpackage

// File: rtl/msm_padd_rb_if.sv
// PADD result-buffer bus: PADD result input, controller pop requests, head/head+1 operands
// and status flags. master = controller/PADD side, slave = result buffer.
interface msm_padd_rb_if #(
  parameter int unsigned WIDTH_ID   = 2,
  parameter int unsigned WIDTH_DATA = 384,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH)
);
  localparam int unsigned W = WIDTH_ID + 3 * WIDTH_DATA;

  logic [W-1:0] data_from_padd;
  logic         padd_out_valid;
  logic         pop;
  logic         pop2;
  logic [W-1:0] data_2_padd_rb;
  logic [W-1:0] data_2_padd_rb_nxt;
  logic         rb_valid;
  logic         rb_pair_valid;
  logic [AW:0]  rb_count;
  logic         rb_almost_full;
  logic         rb_overflow;
  logic         rb_underflow;

  modport master (
    output data_from_padd, padd_out_valid, pop, pop2,
    input  data_2_padd_rb, data_2_padd_rb_nxt, rb_valid, rb_pair_valid, rb_count,
           rb_almost_full, rb_overflow, rb_underflow
  );

  modport slave (
    input  data_from_padd, padd_out_valid, pop, pop2,
    output data_2_padd_rb, data_2_padd_rb_nxt, rb_valid, rb_pair_valid, rb_count,
           rb_almost_full, rb_overflow, rb_underflow
  );
endinterface

// File: rtl/msm_rb_mem.sv
// Result-buffer storage: 1 write / 2 asynchronous read register array, no reset.
module msm_rb_mem #(
  parameter int unsigned W     = 1154,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr0,
  input  logic [AW-1:0] raddr1,
  output logic [W-1:0]  rdata0,
  output logic [W-1:0]  rdata1
);
  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata0 = mem[raddr0];
  assign rdata1 = mem[raddr1];
endmodule

// File: rtl/msm_padd_rb.sv
// PADD result buffer: in-order circular store of PADD results, presenting head and head+1
// as registered operands. Define MSM_RB_BUBBLE_FILTER_EN to drop all-zero pushes.
module msm_padd_rb
  import msm_pkg::*;
#(
  parameter int unsigned WIDTH_ID   = MSM_WIDTH_ID,
  parameter int unsigned WIDTH_DATA = MSM_WIDTH_DATA,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned AW         = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  msm_padd_rb_if.slave rb
);
  localparam int unsigned W = WIDTH_ID + 3 * WIDTH_DATA;

  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;

  ptr_t         wp_q, rp_q, wp_d, rp_d, rp_nxt_d;
  cnt_t         count_q, count_d;
  logic [1:0]   pop_n;
  logic         push_req, push, full, ovf_set, unf_set;
  logic         af_q, ovf_q, unf_q;
  rb_occ_e      occ_q, occ_d;
  logic [W-1:0] rd_head, rd_nxt, head_d, nxt_d, head_q, nxt_q;

  msm_rb_mem #(
    .W     (W),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk    (clk),
    .we     (push),
    .waddr  (wp_q),
    .wdata  (rb.data_from_padd),
    .raddr0 (rp_d),
    .raddr1 (rp_nxt_d),
    .rdata0 (rd_head),
    .rdata1 (rd_nxt)
  );

  always_comb begin
`ifdef MSM_RB_BUBBLE_FILTER_EN
    push_req = rb.padd_out_valid && (rb.data_from_padd != BUBBLE[W-1:0]);
`else
    push_req = rb.padd_out_valid;
`endif
    // pop2 dominates pop; an illegal request moves nothing and only flags underflow.
    pop_n   = 2'd0;
    unf_set = 1'b0;
    if (rb.pop2) begin
      if (count_q >= cnt_t'(2)) pop_n = 2'd2;
      else                      unf_set = 1'b1;
    end else if (rb.pop) begin
      if (count_q != '0) pop_n = 2'd1;
      else               unf_set = 1'b1;
    end

    full     = (count_q == cnt_t'(DEPTH)) && (pop_n == 2'd0);
    push     = push_req && !full;
    ovf_set  = push_req && full;
    count_d  = count_q + cnt_t'(push) - cnt_t'(pop_n);
    wp_d     = wp_q + ptr_t'(push);
    rp_d     = rp_q + ptr_t'(pop_n);
    rp_nxt_d = rp_d + ptr_t'(1);

    // The array only sees this cycle's write after the edge, so forward it when it
    // lands on the new head (empty->1) or head+1 (1->2).
    if (count_d == '0)                 head_d = '0;
    else if (push && (wp_q == rp_d))   head_d = rb.data_from_padd;
    else                               head_d = rd_head;

    if (count_d < cnt_t'(2))              nxt_d = '0;
    else if (push && (wp_q == rp_nxt_d))  nxt_d = rb.data_from_padd;
    else                                  nxt_d = rd_nxt;

    if (count_d == '0)                  occ_d = OccEmpty;
    else if (count_d == cnt_t'(1))      occ_d = OccOne;
    else if (count_d == cnt_t'(DEPTH))  occ_d = OccFull;
    else                                occ_d = OccMulti;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
      occ_q   <= OccEmpty;
      head_q  <= '0;
      nxt_q   <= '0;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
      occ_q   <= occ_d;
      head_q  <= head_d;
      nxt_q   <= nxt_d;
      af_q    <= (count_d >= cnt_t'(DEPTH - 4));
      ovf_q   <= ovf_q | ovf_set;
      unf_q   <= unf_q | unf_set;
    end
  end

  assign rb.data_2_padd_rb     = head_q;
  assign rb.data_2_padd_rb_nxt = nxt_q;
  assign rb.rb_count           = count_q;
  assign rb.rb_valid           = (occ_q != OccEmpty);
  assign rb.rb_pair_valid      = (occ_q == OccMulti) || (occ_q == OccFull);
  assign rb.rb_almost_full     = af_q;
  assign rb.rb_overflow        = ovf_q;
  assign rb.rb_underflow       = unf_q;
endmodule
